// File: rtl/id_ex_queue_if.sv
// Decode packet type and the id_stage_if bundle between decode and execute.
// Shared by the decode stage, id_ex_queue and the execute stage.
package id_ex_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] lsu_data;
    logic [3:0]  lsu_op;
    logic [31:0] oprand1;
    logic [31:0] oprand2;
    logic [7:0]  ex_op;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [3:0]  except_type;
    logic [31:0] except_pc;
    logic [4:0]  rw_addr;
    logic        rw_en;
  } id_ex_t;
endpackage

interface id_stage_if;
  import id_ex_pkg::*;
  id_ex_t pkt;
  modport i (input pkt);
  modport o (output pkt);
endinterface

// File: rtl/id_ex_queue.sv
// id_ex_queue: decode-to-execute packet FIFO with flush and bubble output.
// Define ID_EX_QUEUE_BYPASS_EN for a same-cycle path when the queue is empty.
module id_ex_queue
  import id_ex_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  id_stage_if.i            id_in,
  input  logic             in_valid,
  output logic             in_ready,
  id_stage_if.o            ex_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  id_ex_t           mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty;
  logic             byp;
  logic             thru;
  logic             push;
  logic             pop;

  assign empty    = cnt_q == '0;
  assign in_ready = (cnt_q != CNT_W'(DEPTH)) && !rst;

`ifdef ID_EX_QUEUE_BYPASS_EN
  assign byp = empty && in_valid && !flush && !rst;
`else
  assign byp = 1'b0;
`endif

  // A bypassed packet consumed immediately never touches storage.
  assign thru      = byp && out_ready;
  assign out_valid = !rst && (!empty || byp);
  assign push      = in_valid && in_ready && !flush && !thru;
  assign pop       = out_valid && out_ready && !flush && !thru;

  assign ex_out.pkt = (!rst && !empty) ? mem_q[rd_q] :
                      byp              ? id_in.pkt   : '0;
  assign count      = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= id_in.pkt;
  end
endmodule
